vga_rx_capture: RTL and testbench

- Receiving end of the VGA link: samples hsync/vsync/rgb from a VGA timing source on the pixel clock and recovers the active-area pixel stream.
- Outputs a per-pixel valid/data pair plus coordinates, in the same pi_flag/pi_data form our image pipeline (sobel, vga_pic buffers) already consumes.
- Checks incoming line and frame timing against the parameters and only emits pixels while locked.

---
 rtl/vga_rx_capture.sv | 153 +++++++++++++++
 tb/tb_vga_rx_capture.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_rx_capture.sv
`timescale 1ns/1ps
// vga_rx_capture: receiving end of the VGA link. Recovers the active-area pixel
// stream (pi_flag/pi_data style) and checks line/frame timing, emitting only while locked.
module vga_rx_capture #(
    parameter int H_SYNC   = 96,
    parameter int H_PRE    = 48,
    parameter int H_VALID  = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_SYNC   = 2,
    parameter int V_PRE    = 33,
    parameter int V_VALID  = 480,
    parameter int V_TOTAL  = 525,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic       vga_clk,
    input  logic       sys_rst_n,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [7:0] rgb,
    output logic       po_flag,
    output logic [7:0] po_data,
    output logic [9:0] po_x,
    output logic [9:0] po_y,
    output logic       frame_start,
    output logic       locked,
    output logic       timing_err,
    output logic [1:0] state_dbg
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SYNC = 2'd1;
    localparam logic [1:0] S_LOCK = 2'd2;

    localparam logic [10:0] CNT_MAX = 11'h7ff;
    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_BEG   = 11'(H_SYNC + H_PRE);
    localparam logic [10:0] H_END   = 11'(H_SYNC + H_PRE + H_VALID - 1);
    localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_BEG   = 11'(V_SYNC + V_PRE);
    localparam logic [10:0] V_END   = 11'(V_SYNC + V_PRE + V_VALID - 1);

    logic       hs_in, vs_in;
    logic       s1_h, s1_v, s2_h, s2_v;
    logic [7:0] s1_rgb, s2_rgb;
    logic       h_rise, v_rise;
    logic [10:0] h_cnt, v_cnt;
    logic [1:0] state, state_nxt;
    logic       viol_h_early, viol_h_late, viol_v_early, viol_v_late, viol;
    logic       h_act, v_act, flag_nxt;
    logic [9:0] x_nxt, y_nxt;

    // Syncs are normalised on entry so everything downstream sees 1 = pulse.
    assign hs_in = SYNC_POL ? hsync : ~hsync;
    assign vs_in = SYNC_POL ? vsync : ~vsync;

    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            s1_h   <= 1'b0;
            s1_v   <= 1'b0;
            s2_h   <= 1'b0;
            s2_v   <= 1'b0;
            s1_rgb <= '0;
            s2_rgb <= '0;
        end else begin
            s1_h   <= hs_in;
            s1_v   <= vs_in;
            s2_h   <= s1_h;
            s2_v   <= s1_v;
            s1_rgb <= rgb;
            s2_rgb <= s1_rgb;
        end
    end

    assign h_rise = s1_h & ~s2_h;
    assign v_rise = s1_v & ~s2_v;

    // Counters reload on the edge seen in s1, so after the update they line up with s2_rgb.
    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            if (h_rise)
                h_cnt <= '0;
            else if (h_cnt != CNT_MAX)
                h_cnt <= h_cnt + 11'd1;

            if (v_rise)
                v_cnt <= '0;
            else if (h_rise && (v_cnt != CNT_MAX))
                v_cnt <= v_cnt + 11'd1;
        end
    end

    assign viol_h_early = h_rise & (state != S_IDLE) & (h_cnt != H_LAST);
    assign viol_h_late  = ~h_rise & (h_cnt == H_LAST);
    assign viol_v_early = v_rise & (state == S_LOCK) & (v_cnt != V_LAST);
    assign viol_v_late  = h_rise & ~v_rise & (v_cnt == V_LAST);
    assign viol         = viol_h_early | viol_h_late | viol_v_early | viol_v_late;

    // A violation outranks a coincident v_rise; a short frame in S_SYNC only restarts the measurement.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (v_rise)
                    state_nxt = S_SYNC;
            end
            S_SYNC: begin
                if (viol)
                    state_nxt = S_IDLE;
                else if (v_rise && (v_cnt == V_LAST))
                    state_nxt = S_LOCK;
            end
            S_LOCK: begin
                if (viol)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign h_act    = (h_cnt >= H_BEG) && (h_cnt <= H_END);
    assign v_act    = (v_cnt >= V_BEG) && (v_cnt <= V_END);
    assign flag_nxt = (state_nxt == S_LOCK) & h_act & v_act;
    assign x_nxt    = h_cnt[9:0] - H_BEG[9:0];
    assign y_nxt    = v_cnt[9:0] - V_BEG[9:0];

    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            state       <= S_IDLE;
            locked      <= 1'b0;
            timing_err  <= 1'b0;
            po_flag     <= 1'b0;
            po_data     <= '0;
            po_x        <= '0;
            po_y        <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            locked      <= (state_nxt == S_LOCK);
            timing_err  <= viol;
            po_flag     <= flag_nxt;
            po_data     <= flag_nxt ? s2_rgb : 8'd0;
            po_x        <= flag_nxt ? x_nxt : 10'd0;
            po_y        <= flag_nxt ? y_nxt : 10'd0;
            frame_start <= flag_nxt & (x_nxt == 10'd0) & (y_nxt == 10'd0);
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_vga_rx_capture.sv
`timescale 1ns/1ps
// Bench for vga_rx_capture: a small VGA generator drives an active-high and an
// active-low instance in parallel; a scoreboard checks pixels, latency, lock and errors.
module tb_vga_rx_capture;

    localparam int H_SYNC = 4, H_PRE = 4, H_VALID = 8, H_TOTAL = 20;
    localparam int V_SYNC = 1, V_PRE = 2, V_VALID = 4, V_TOTAL = 10;
    localparam int EW = 60;  // {cycle[31:0], y[9:0], x[9:0], data[7:0]}
    localparam logic [1:0] ST_IDLE = 2'd0, ST_SYNC = 2'd1, ST_LOCK = 2'd2;

    // ---------------- clock / reset ----------------
    logic vga_clk = 1'b0;
    logic sys_rst_n;
    int unsigned cyc = 0;

    always #5 vga_clk = ~vga_clk;
    always @(posedge vga_clk) cyc <= cyc + 1;

    logic       hs, vs, hs_n, vs_n;
    logic [7:0] rgb;
    assign hs_n = ~hs;
    assign vs_n = ~vs;

    logic       p_flag, n_flag, p_fs, n_fs, p_locked, n_locked, p_err, n_err;
    logic [7:0] p_data, n_data;
    logic [9:0] p_x, p_y, n_x, n_y;
    logic [1:0] p_state, n_state;

    vga_rx_capture #(
        .H_SYNC(H_SYNC), .H_PRE(H_PRE), .H_VALID(H_VALID), .H_TOTAL(H_TOTAL),
        .V_SYNC(V_SYNC), .V_PRE(V_PRE), .V_VALID(V_VALID), .V_TOTAL(V_TOTAL),
        .SYNC_POL(1'b1)
    ) dut_pos (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .hsync(hs), .vsync(vs), .rgb(rgb),
        .po_flag(p_flag), .po_data(p_data), .po_x(p_x), .po_y(p_y),
        .frame_start(p_fs), .locked(p_locked), .timing_err(p_err), .state_dbg(p_state)
    );

    vga_rx_capture #(
        .H_SYNC(H_SYNC), .H_PRE(H_PRE), .H_VALID(H_VALID), .H_TOTAL(H_TOTAL),
        .V_SYNC(V_SYNC), .V_PRE(V_PRE), .V_VALID(V_VALID), .V_TOTAL(V_TOTAL),
        .SYNC_POL(1'b0)
    ) dut_neg (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .hsync(hs_n), .vsync(vs_n), .rgb(rgb),
        .po_flag(n_flag), .po_data(n_data), .po_x(n_x), .po_y(n_y),
        .frame_start(n_fs), .locked(n_locked), .timing_err(n_err), .state_dbg(n_state)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    int n_checks = 0;
    int n_fail = 0;
    int flag_cnt[2] = '{0, 0};
    int fs_cnt[2] = '{0, 0};
    int err_cnt[2] = '{0, 0};
    int push_cnt = 0;
    int fs_push = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic mon(input int idx, input logic flag, input logic [7:0] data,
                       input logic [9:0] x, input logic [9:0] y, input logic fs, input logic err);
        logic [EW-1:0] e;
        string pre;
        bit empty;
        pre = (idx == 0) ? "pos" : "neg";
        if (err) err_cnt[idx]++;
        if (flag) begin
            flag_cnt[idx]++;
            if (fs) fs_cnt[idx]++;
            empty = (idx == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
            if (empty) begin
                check({pre, "_unexpected_pixel"}, 64'(flag), 64'd0);
            end else begin
                if (idx == 0) e = exp_q0.pop_front();
                else          e = exp_q1.pop_front();
                check({pre, "_latency"}, 64'(cyc), 64'(e[59:28]));
                check({pre, "_pixel_yxd"}, 64'({y, x, data}), 64'(e[27:0]));
                check({pre, "_frame_start"}, 64'(fs), 64'((e[27:18] == 10'd0) && (e[17:8] == 10'd0)));
            end
        end else begin
            check({pre, "_idle_outputs"}, 64'({fs, y, x, data}), 64'd0);
        end
    endtask

    always @(negedge vga_clk) begin
        mon(0, p_flag, p_data, p_x, p_y, p_fs, p_err);
        mon(1, n_flag, n_data, n_x, n_y, n_fs, n_err);
    end

    task automatic reset_check(input string tag);
        check({tag, "_pos_flag_fs"}, 64'({p_flag, p_fs}), 64'd0);
        check({tag, "_pos_data_xy"}, 64'({p_data, p_x, p_y}), 64'd0);
        check({tag, "_pos_lock_err_state"}, 64'({p_locked, p_err, p_state}), 64'd0);
        check({tag, "_neg_flag_fs"}, 64'({n_flag, n_fs}), 64'd0);
        check({tag, "_neg_data_xy"}, 64'({n_data, n_x, n_y}), 64'd0);
        check({tag, "_neg_lock_err_state"}, 64'({n_locked, n_err, n_state}), 64'd0);
    endtask

    // ---------------- driver ----------------
    task automatic drive_line(input int v, input int len, input bit hs_en, input bit emit, input int rst_h);
        logic [EW-1:0] e;
        for (int h = 0; h < len; h++) begin
            @(posedge vga_clk);
            #1;
            if (rst_h >= 0 && h == rst_h + 1) begin
                reset_check("mid_reset");
                sys_rst_n = 1'b1;
            end
            if (h == rst_h) sys_rst_n = 1'b0;
            hs  = hs_en && (h < H_SYNC);
            vs  = (v < V_SYNC);
            rgb = {4'(v), 4'(h)};
            // Pixels whose output edge would land on or after the reset edge are lost.
            if (emit && h >= H_SYNC + H_PRE && h < H_SYNC + H_PRE + H_VALID &&
                v >= V_SYNC + V_PRE && v < V_SYNC + V_PRE + V_VALID &&
                !(rst_h >= 0 && h >= rst_h - 2)) begin
                e = {32'(cyc + 3), 10'(v - (V_SYNC + V_PRE)), 10'(h - (H_SYNC + H_PRE)), 4'(v), 4'(h)};
                exp_q0.push_back(e);
                exp_q1.push_back(e);
                push_cnt++;
                if (h == H_SYNC + H_PRE && v == V_SYNC + V_PRE) fs_push++;
            end
        end
    endtask

    task automatic drive_frame(input int nlines, input int emit_until, input int short_v,
                               input int miss_v, input int rst_v);
        for (int v = 0; v < nlines; v++)
            drive_line(v, (v == short_v) ? H_TOTAL - 1 : H_TOTAL, v != miss_v,
                       v < emit_until, (v == rst_v) ? 14 : -1);
    endtask

    task automatic frame_end(input int f, input logic [1:0] st, input int errs);
        string t;
        t = $sformatf("f%0d", f);
        check({t, "_pos_state"}, 64'(p_state), 64'(st));
        check({t, "_neg_state"}, 64'(n_state), 64'(st));
        check({t, "_pos_locked"}, 64'(p_locked), 64'(st == ST_LOCK));
        check({t, "_neg_locked"}, 64'(n_locked), 64'(st == ST_LOCK));
        check({t, "_pos_pixels"}, 64'(flag_cnt[0]), 64'(push_cnt));
        check({t, "_neg_pixels"}, 64'(flag_cnt[1]), 64'(push_cnt));
        check({t, "_pos_frame_start"}, 64'(fs_cnt[0]), 64'(fs_push));
        check({t, "_neg_frame_start"}, 64'(fs_cnt[1]), 64'(fs_push));
        check({t, "_pos_timing_err"}, 64'(err_cnt[0]), 64'(errs));
        check({t, "_neg_timing_err"}, 64'(err_cnt[1]), 64'(errs));
        flag_cnt = '{0, 0};
        fs_cnt   = '{0, 0};
        err_cnt  = '{0, 0};
        push_cnt = 0;
        fs_push  = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        sys_rst_n = 1'b0;
        hs  = 1'b0;
        vs  = 1'b0;
        rgb = 8'd0;
        repeat (3) @(posedge vga_clk);
        #1;
        reset_check("init");
        sys_rst_n = 1'b1;

        // nominal acquisition: first vsync edge syncs, second locks
        drive_frame(10, 0, -1, -1, -1);   frame_end(0, ST_SYNC, 0);
        drive_frame(10, 10, -1, -1, -1);  frame_end(1, ST_LOCK, 0);
        // line 4 shortened to 19 clocks: lines 3-4 emitted, then dark until relock
        drive_frame(10, 5, 4, -1, -1);    frame_end(2, ST_IDLE, 1);
        drive_frame(10, 0, -1, -1, -1);   frame_end(3, ST_SYNC, 0);
        drive_frame(10, 10, -1, -1, -1);  frame_end(4, ST_LOCK, 0);
        // line 7 without hsync pulse
        drive_frame(10, 10, -1, 7, -1);   frame_end(5, ST_IDLE, 1);
        drive_frame(10, 0, -1, -1, -1);   frame_end(6, ST_SYNC, 0);
        drive_frame(10, 10, -1, -1, -1);  frame_end(7, ST_LOCK, 0);
        // V_TOTAL-1 lines: the early vsync must drop to idle, not advance to sync
        drive_frame(9, 10, -1, -1, -1);   frame_end(8, ST_LOCK, 0);
        drive_frame(10, 0, -1, -1, -1);   frame_end(9, ST_IDLE, 1);
        drive_frame(10, 0, -1, -1, -1);   frame_end(10, ST_SYNC, 0);
        drive_frame(10, 10, -1, -1, -1);  frame_end(11, ST_LOCK, 0);
        // one-clock reset while po_x = 3 on line 4
        drive_frame(10, 5, -1, -1, 4);    frame_end(12, ST_IDLE, 0);
        drive_frame(10, 0, -1, -1, -1);   frame_end(13, ST_SYNC, 0);
        drive_frame(10, 10, -1, -1, -1);  frame_end(14, ST_LOCK, 0);

        repeat (4) @(posedge vga_clk);
        #1;
        check("pos_queue_left", 64'(exp_q0.size()), 64'd0);
        check("neg_queue_left", 64'(exp_q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
